hub75_scan_reader: RTL and testbench

- Read-side consumer of the frame triple buffer.
- Scans the displayed buffer row pair by row pair and serialises pixels onto a HUB75 64x64 panel at 1/32 scan.
- Uses 8-plane binary-coded modulation (BCM).
- Pulses frame_tick at each frame boundary so the buffer-select logic can rotate buffers.

---
 rtl/hub75_scan_reader_pkg.sv | 26 ++
 rtl/hub75_scan_reader_if.sv | 35 +++
 rtl/hub75_scan_reader_bcm_timer.sv | 50 +++++
 rtl/hub75_scan_reader.sv | 186 ++++++++++++++++++
 tb/tb_hub75_scan_reader.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/hub75_scan_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hub75_pkg
// Brief    : Shared state encoding and pixel/address field layout for the
//            HUB75 scan reader.
// Revision : 1.0
// ============================================================================
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    BLANK   = 3'd2,
    LATCH   = 3'd3,
    DISPLAY = 3'd4
  } state_e;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  localparam int COL_W = 6;
  localparam int ROW_W = 5;

endpackage
`default_nettype wire

// File: rtl/hub75_scan_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : hub75_scan_reader_if
// Brief    : Buffer read port plus HUB75 panel pins seen by the scan reader.
// Revision : 1.0
// ============================================================================
interface hub75_scan_reader_if;
  import hub75_pkg::*;

  logic                   enable;
  logic [ROW_W+COL_W-1:0] addrb;
  logic [23:0]            douta;
  logic [23:0]            doutb;
  logic                   r1, g1, b1;
  logic                   r2, g2, b2;
  logic                   panel_clk;
  logic                   lat;
  logic                   oe_n;
  logic [ROW_W-1:0]       row_addr;
  logic                   frame_tick;

  modport master (
    input  enable, douta, doutb,
    output addrb, r1, g1, b1, r2, g2, b2, panel_clk, lat, oe_n, row_addr,
           frame_tick
  );

  modport slave (
    output enable, douta, doutb,
    input  addrb, r1, g1, b1, r2, g2, b2, panel_clk, lat, oe_n, row_addr,
           frame_tick
  );

endinterface
`default_nettype wire

// File: rtl/hub75_scan_reader_bcm_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcm_timer
// Brief    : Loadable down-counter timing BCM display windows and dead time.
// Revision : 1.0
// ============================================================================
module bcm_timer #(
  parameter int BITS        = 8,
  parameter int BASE_CYCLES = 4,
  parameter int DEAD_CYCLES = 2
) (
  input  wire logic                    clkb,
  input  wire logic                    reset,
  input  wire logic                    i_load,
  input  wire logic                    i_dead,
  input  wire logic [$clog2(BITS)-1:0] i_plane,
  output logic                         o_done
);

  localparam int c_CNT_W = $clog2(BASE_CYCLES << (BITS - 1)) + 1;

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_busy;
  logic [c_CNT_W-1:0] w_len;

  always_comb begin
    w_len = i_dead ? c_CNT_W'(DEAD_CYCLES) : (c_CNT_W'(BASE_CYCLES) << i_plane);
  end

  // done is asserted during the last cycle of the loaded window
  always_ff @(posedge clkb) begin
    if (reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= w_len - c_CNT_W'(1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end
    end
  end

  assign o_done = r_busy && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/hub75_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : hub75_scan_reader
// Brief    : Scans the displayed frame buffer onto a 64x64 1/32-scan HUB75
//            panel with LSB-first binary-coded modulation.
// Revision : 1.0
// ============================================================================
module hub75_scan_reader
  import hub75_pkg::*;
#(
  parameter int COLS        = 64,
  parameter int ROWS        = 32,
  parameter int BITS        = 8,
  parameter int BASE_CYCLES = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int RD_LATENCY  = 1
) (
  input wire logic            clkb,
  input wire logic            reset,
  hub75_scan_reader_if.master bus
);

  localparam int   c_PLANE_W  = $clog2(BITS);
  localparam int   c_SC_LAST  = 2 * COLS + RD_LATENCY;
  localparam int   c_SC_W     = $clog2(c_SC_LAST + 1);
  localparam logic c_LAT_ODD  = 1'(RD_LATENCY % 2);

  state_e                 r_state;
  logic [ROW_W-1:0]       r_row;
  logic [c_PLANE_W-1:0]   r_plane;
  logic [c_SC_W-1:0]      r_sc;
  logic [ROW_W+COL_W-1:0] r_addrb;
  logic                   r_r1, r_g1, r_b1, r_r2, r_g2, r_b2;
  logic                   r_panel_clk;
  logic                   r_lat;
  logic                   r_oe_n;
  logic [ROW_W-1:0]       r_row_addr;
  logic                   r_frame_tick;

  logic                   w_shift_last;
  logic                   w_data_ready;
  logic                   w_pix_hi;
  logic                   w_tmr_load;
  logic                   w_tmr_dead;
  logic                   w_tmr_done;
  logic [BITS-1:0]        w_ra, w_ga, w_ba, w_rb, w_gb, w_bb;

  assign w_ra = bus.douta[R_LSB +: BITS];
  assign w_ga = bus.douta[G_LSB +: BITS];
  assign w_ba = bus.douta[B_LSB +: BITS];
  assign w_rb = bus.doutb[R_LSB +: BITS];
  assign w_gb = bus.doutb[G_LSB +: BITS];
  assign w_bb = bus.doutb[B_LSB +: BITS];

  // Data for column c is valid RD_LATENCY cycles after its address; even
  // offsets from there present a pixel with panel_clk low, odd ones raise it.
  assign w_shift_last = (r_sc == c_SC_W'(c_SC_LAST));
  assign w_data_ready = (r_sc >= c_SC_W'(RD_LATENCY));
  assign w_pix_hi     = r_sc[0] ^ c_LAT_ODD;

  assign w_tmr_load = ((r_state == SHIFT) && w_shift_last) || (r_state == LATCH);
  assign w_tmr_dead = (r_state == SHIFT);

  bcm_timer #(
    .BITS        (BITS),
    .BASE_CYCLES (BASE_CYCLES),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_bcm_timer (
    .clkb    (clkb),
    .reset   (reset),
    .i_load  (w_tmr_load),
    .i_dead  (w_tmr_dead),
    .i_plane (r_plane),
    .o_done  (w_tmr_done)
  );

  always_ff @(posedge clkb) begin
    if (reset) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_plane      <= '0;
      r_sc         <= '0;
      r_addrb      <= '0;
      {r_r1, r_g1, r_b1, r_r2, r_g2, r_b2} <= '0;
      r_panel_clk  <= 1'b0;
      r_lat        <= 1'b0;
      r_oe_n       <= 1'b1;
      r_row_addr   <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      r_lat        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.enable) begin
            r_state <= SHIFT;
            r_row   <= '0;
            r_plane <= '0;
            r_sc    <= '0;
            r_addrb <= '0;
          end
        end
        SHIFT: begin
          r_sc <= r_sc + c_SC_W'(1);
          if (w_shift_last) begin
            r_state     <= BLANK;
            r_panel_clk <= 1'b0;
            r_row_addr  <= r_row;
          end else begin
            if (r_sc[0] && (r_addrb[COL_W-1:0] != COL_W'(COLS - 1))) begin
              r_addrb[COL_W-1:0] <= r_addrb[COL_W-1:0] + COL_W'(1);
            end
            if (w_data_ready) begin
              if (!w_pix_hi) begin
                r_r1        <= w_ra[r_plane];
                r_g1        <= w_ga[r_plane];
                r_b1        <= w_ba[r_plane];
                r_r2        <= w_rb[r_plane];
                r_g2        <= w_gb[r_plane];
                r_b2        <= w_bb[r_plane];
                r_panel_clk <= 1'b0;
              end else begin
                r_panel_clk <= 1'b1;
              end
            end
          end
        end
        BLANK: begin
          if (w_tmr_done) begin
            r_state <= LATCH;
            r_lat   <= 1'b1;
          end
        end
        LATCH: begin
          r_state <= DISPLAY;
          r_oe_n  <= 1'b0;
        end
        DISPLAY: begin
          if (w_tmr_done) begin
            r_oe_n <= 1'b1;
            r_sc   <= '0;
            if (r_plane != c_PLANE_W'(BITS - 1)) begin
              r_plane <= r_plane + c_PLANE_W'(1);
              r_state <= SHIFT;
              r_addrb <= {r_row, {COL_W{1'b0}}};
            end else begin
              r_plane <= '0;
              if (r_row != ROW_W'(ROWS - 1)) begin
                r_row   <= r_row + ROW_W'(1);
                r_state <= SHIFT;
                r_addrb <= {r_row + ROW_W'(1), {COL_W{1'b0}}};
              end else begin
                r_row        <= '0;
                r_frame_tick <= 1'b1;
                r_addrb      <= '0;
                if (bus.enable) begin
                  r_state <= SHIFT;
                end else begin
                  r_state    <= IDLE;
                  r_row_addr <= '0;
                  {r_r1, r_g1, r_b1, r_r2, r_g2, r_b2} <= '0;
                end
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.addrb      = r_addrb;
  assign bus.r1         = r_r1;
  assign bus.g1         = r_g1;
  assign bus.b1         = r_b1;
  assign bus.r2         = r_r2;
  assign bus.g2         = r_g2;
  assign bus.b2         = r_b2;
  assign bus.panel_clk  = r_panel_clk;
  assign bus.lat        = r_lat;
  assign bus.oe_n       = r_oe_n;
  assign bus.row_addr   = r_row_addr;
  assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_scan_reader
// Brief    : Self-checking bench: timeline model of a HUB75 BCM frame checked
//            cycle by cycle against the scan reader.
// Revision : 1.0
// ============================================================================
module tb_hub75_scan_reader;

  localparam int COLS = 64, ROWS = 32, BITS = 8, BASE = 4, DEAD = 2, LAT = 1;
  localparam int SEG_S     = 2 * COLS + LAT + 1;
  localparam int ROW_LEN   = BITS * (SEG_S + DEAD + 1) + BASE * ((1 << BITS) - 1);
  localparam int FRAME_LEN = ROWS * ROW_LEN;
  localparam logic [25:0] IDLE_VEC = 26'h000_1000;
  localparam logic [25:0] TICK_VEC = 26'h000_1800;

  logic clkb = 1'b0;
  logic reset;
  always #5 clkb = ~clkb;

  hub75_scan_reader_if bus();

  hub75_scan_reader dut (
    .clkb  (clkb),
    .reset (reset),
    .bus   (bus)
  );

  logic [23:0] mem_a [2048];
  logic [23:0] mem_b [2048];

  always @(posedge clkb) begin
    bus.douta <= mem_a[bus.addrb];
    bus.doutb <= mem_b[bus.addrb];
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s @%0d: observed %h expected %h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [25:0] obs_vec();
    return {bus.addrb, bus.panel_clk, bus.lat, bus.oe_n, bus.frame_tick,
            bus.row_addr, bus.r1, bus.g1, bus.b1, bus.r2, bus.g2, bus.b2};
  endfunction

  // Expected pins at cycle t of a frame started from IDLE; mk clears
  // fields whose value the protocol leaves open at that cycle.
  function automatic void model(input int t, output logic [25:0] ev,
                                output logic [25:0] mk);
    int row, o, p, c, ra;
    logic [10:0] ad;
    logic        pclk, lt, oe;
    logic [5:0]  rgb;
    logic [23:0] a, b;
    row = t / ROW_LEN;
    o   = t % ROW_LEN;
    p   = 0;
    while (o >= SEG_S + DEAD + 1 + (BASE << p)) begin
      o -= SEG_S + DEAD + 1 + (BASE << p);
      p++;
    end
    ra   = (p == 0 && o < SEG_S) ? ((row == 0) ? 0 : row - 1) : row;
    ad   = '0;
    pclk = 1'b0;
    lt   = 1'b0;
    oe   = 1'b1;
    rgb  = '0;
    mk   = '1;
    if (o < SEG_S) begin
      c  = (o / 2 < COLS) ? o / 2 : COLS - 1;
      ad = 11'(row * COLS + c);
      if (o >= LAT + 1) begin
        c    = (o - LAT - 1) / 2;
        pclk = ((o - LAT - 1) % 2) == 1;
        a    = mem_a[row * COLS + c];
        b    = mem_b[row * COLS + c];
        rgb  = {a[16+p], a[8+p], a[p], b[16+p], b[8+p], b[p]};
      end else begin
        mk[5:0] = '0;
      end
    end else begin
      mk[25:15] = '0;
      mk[5:0]   = '0;
      if (o == SEG_S + DEAD) lt = 1'b1;
      else if (o > SEG_S + DEAD) oe = 1'b0;
    end
    ev = {ad, pclk, lt, oe, 1'b0, 5'(ra), rgb};
  endfunction

  logic [25:0] ev, mk, obs;
  int t_drop, t_rst, rst_plane;
  int edges, lat_cnt, tick_cnt, viol, run, nwin, t5, tl5;
  int win [BITS];
  logic prev_pclk;
  logic [4:0] prev_ra;

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b1;
    for (int a = 0; a < 2048; a++) begin
      if (a < COLS) begin
        mem_a[a] = {8'hA5, 8'(a), 8'h0F};
        mem_b[a] = ~mem_a[a];
      end else begin
        mem_a[a] = 24'($urandom);
        mem_b[a] = 24'($urandom);
      end
    end
    t_drop = 10 * ROW_LEN + int'($urandom_range(0, ROW_LEN - 1));

    // Reset held with enable high: pins stay at reset values
    for (int i = 0; i < 3; i++) begin
      @(negedge clkb);
      check("reset_hold", i, 32'(obs_vec()), 32'(IDLE_VEC));
    end
    reset = 1'b0;

    edges = 0; lat_cnt = 0; tick_cnt = 0; viol = 0; run = 0; nwin = 0;
    t5 = -1; tl5 = -1; prev_pclk = 1'b0; prev_ra = '0;
    for (int t = 0; t < FRAME_LEN; t++) begin
      @(negedge clkb);
      if (t == t_drop) bus.enable = 1'b0;
      model(t, ev, mk);
      obs = obs_vec();
      if (n_mis < 40) check("scan", t, 32'(obs & mk), 32'(ev & mk));
      if (bus.panel_clk && !prev_pclk && t < SEG_S) edges++;
      if (bus.lat) lat_cnt++;
      if (bus.frame_tick) tick_cnt++;
      if (!bus.oe_n && (bus.lat || bus.row_addr != prev_ra)) viol++;
      if (!bus.oe_n) begin
        run++;
      end else begin
        if (run > 0 && nwin < BITS) begin
          win[nwin] = run;
          nwin++;
        end
        run = 0;
      end
      if (bus.row_addr == 5'd5 && t5 < 0) t5 = t;
      if (bus.lat && t5 >= 0 && tl5 < 0) tl5 = t;
      if (t == 5 * ROW_LEN + 6) check("row5_col3_addr", t, 32'(bus.addrb), 32'h143);
      prev_pclk = bus.panel_clk;
      prev_ra   = bus.row_addr;
    end

    // Frame end with enable dropped: tick, then IDLE at reset values
    @(negedge clkb);
    if (bus.frame_tick) tick_cnt++;
    check("frame_end", FRAME_LEN, 32'(obs_vec()), 32'(TICK_VEC));
    check("row0_p0_edges", 0, 32'(edges), 32'(COLS));
    check("lat_pulses", 0, 32'(lat_cnt), 32'(ROWS * BITS));
    check("tick_count", 0, 32'(tick_cnt), 32'd1);
    check("oe_overlap", 0, 32'(viol), 32'd0);
    check("win_count", 0, 32'(nwin), 32'(BITS));
    for (int k = 0; k < BITS; k++) check("oe_window", k, 32'(win[k]), 32'(BASE << k));
    check("row5_addr_time", 0, 32'(t5), 32'(5 * ROW_LEN + SEG_S));
    check("row5_dead_lead", 0, 32'(tl5 - t5 >= DEAD), 32'd1);

    for (int i = 0; i < 20; i++) begin
      @(negedge clkb);
      check("idle", i, 32'(obs_vec()), 32'(IDLE_VEC));
    end

    // Re-enable restarts at row 0 plane 0; reset lands inside a DISPLAY window
    bus.enable = 1'b1;
    rst_plane  = int'($urandom_range(3, 6));
    t_rst      = ROW_LEN;
    for (int q = 0; q < rst_plane; q++) t_rst += SEG_S + DEAD + 1 + (BASE << q);
    t_rst += SEG_S + DEAD + 1 + int'($urandom_range(0, (BASE << rst_plane) - 1));
    for (int t = 0; t <= t_rst; t++) begin
      @(negedge clkb);
      model(t, ev, mk);
      obs = obs_vec();
      if (n_mis < 40) check("restart", t, 32'(obs & mk), 32'(ev & mk));
    end
    check("pre_reset_oe", t_rst, 32'(bus.oe_n), 32'd0);
    reset = 1'b1;
    @(negedge clkb);
    check("reset_mid_display", 0, 32'(obs_vec()), 32'(IDLE_VEC));
    bus.enable = 1'b0;
    @(negedge clkb);
    check("reset_hold2", 0, 32'(obs_vec()), 32'(IDLE_VEC));
    reset = 1'b0;
    repeat (3) @(negedge clkb);
    check("idle_after_reset", 0, 32'(obs_vec()), 32'(IDLE_VEC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
